// File: rtl/saida_de_dados_display.sv
// Output I/O stage: captures a signed register value, converts it to sign + 3 BCD
// digits (clamped to 999) and holds the CPU until the operator acknowledges with enter.
module saida_de_dados_display #(
  parameter int LARGURA = 32,
  parameter int ESTAVEL = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               estagioSaidaUC,
  input  logic [LARGURA-1:0] dado,
  input  logic               enter,
  output logic               ocupado,
  output logic               pronto,
  output logic [3:0]         centena,
  output logic [3:0]         dezena,
  output logic [3:0]         unidade,
  output logic               indicaNegativo,
  output logic               estouro
);

  localparam int CW = $clog2(ESTAVEL + 1);
  localparam logic [CW-1:0] LIMITE = CW'(ESTAVEL - 1);

  typedef enum logic [1:0] {OCIOSO, CONVERTE, EXIBE, SOLTA} estado_t;

  estado_t estado_q, estado_d;

  logic          reqAnt_q;
  logic          sinc1_q, sinc2_q, enterDb_q;
  logic [CW-1:0] conta_q;
  logic [9:0]    bin_q;
  logic [11:0]   bcd_q;
  logic [3:0]    iter_q;
  logic          negInt_q, estInt_q;
  logic [3:0]    centena_q, dezena_q, unidade_q;
  logic          indNeg_q, estouro_q;

  logic          pedido, aceita, ultima, virar, aperta, solta;
  logic [10:0]   sat;
  logic [21:0]   deslocado;

  // Magnitude of a two's complement value, clamped to 999; bit 10 flags the clamp.
  function automatic logic [10:0] satura(input logic signed [LARGURA-1:0] v);
    logic [LARGURA-1:0] a;
    a = v[LARGURA-1] ? $unsigned(-v) : $unsigned(v);
    if (a > LARGURA'(999)) return {1'b1, 10'd999};
    return {1'b0, a[9:0]};
  endfunction

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
  function automatic logic [11:0] soma3(input logic [11:0] b);
    logic [11:0] r;
    for (int i = 0; i < 3; i++) begin
      r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
    end
    return r;
  endfunction

  assign pedido    = estagioSaidaUC & ~reqAnt_q;
  assign aceita    = (estado_q == OCIOSO) & pedido;
  assign ultima    = (estado_q == CONVERTE) && (iter_q == 4'd9);
  assign sat       = satura($signed(dado));
  assign deslocado = {soma3(bcd_q), bin_q} << 1;

  // The debounced level flips on the edge where the counter saturates.
  assign virar  = (sinc2_q != enterDb_q) && (conta_q == LIMITE);
  assign aperta = virar & enterDb_q;
  assign solta  = virar & ~enterDb_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= OCIOSO;
    end else begin
      estado_q <= estado_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    ocupado  = 1'b1;
    pronto   = 1'b0;
    unique case (estado_q)
      OCIOSO: begin
        ocupado = 1'b0;
        if (pedido) estado_d = CONVERTE;
      end
      CONVERTE: if (ultima) estado_d = EXIBE;
      EXIBE: begin
        pronto = 1'b1;
        if (aperta) estado_d = SOLTA;
      end
      SOLTA: if (solta) estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sinc1_q   <= 1'b1;
      sinc2_q   <= 1'b1;
      enterDb_q <= 1'b1;
      conta_q   <= '0;
    end else begin
      sinc1_q <= enter;
      sinc2_q <= sinc1_q;
      if (sinc2_q == enterDb_q) begin
        conta_q <= '0;
      end else if (conta_q == LIMITE) begin
        enterDb_q <= sinc2_q;
        conta_q   <= '0;
      end else begin
        conta_q <= conta_q + CW'(1);
      end
    end
  end

  // Display registers change only on the last iteration, so digits never flicker.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      reqAnt_q  <= 1'b0;
      bin_q     <= '0;
      bcd_q     <= '0;
      iter_q    <= '0;
      negInt_q  <= 1'b0;
      estInt_q  <= 1'b0;
      centena_q <= '0;
      dezena_q  <= '0;
      unidade_q <= '0;
      indNeg_q  <= 1'b0;
      estouro_q <= 1'b0;
    end else begin
      reqAnt_q <= estagioSaidaUC;
      if (aceita) begin
        bin_q    <= sat[9:0];
        bcd_q    <= '0;
        iter_q   <= '0;
        negInt_q <= dado[LARGURA-1] & (sat[9:0] != 10'd0);
        estInt_q <= sat[10];
      end else if (estado_q == CONVERTE) begin
        bcd_q  <= deslocado[21:10];
        bin_q  <= deslocado[9:0];
        iter_q <= iter_q + 4'd1;
        if (ultima) begin
          centena_q <= deslocado[21:18];
          dezena_q  <= deslocado[17:14];
          unidade_q <= deslocado[13:10];
          indNeg_q  <= negInt_q;
          estouro_q <= estInt_q;
        end
      end
    end
  end

  assign centena        = centena_q;
  assign dezena         = dezena_q;
  assign unidade        = unidade_q;
  assign indicaNegativo = indNeg_q;
  assign estouro        = estouro_q;

endmodule
